// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: CPU data port (port 0),
// loader/debug DMA port (port 1) and the port 1 lock request.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic          lock1;

  // Requesters drive requests and consume grants / read data.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1, lock1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1
  );

  // The arbiter consumes requests and drives grants / read data.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1, lock1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// Grants are combinational in the request cycle; read data returns one
// cycle later and is steered by a registered per-port valid. Port 1 can
// lock the RAM, but the lock is forcibly released after MAX_LOCK grants
// so port 0 is never starved for longer than that.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_LOCK   = 16
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           ram_en,
  output logic           ram_we,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  input  logic [DW-1:0]  ram_rdata
);

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  arb_state_e state_q;
  logic       last_q;       // port that won the most recent grant
  logic [7:0] lock_cnt_q;   // port 1 grants taken in the current lock
  logic       rvalid0_q;
  logic       rvalid1_q;

  logic       gnt0_s;
  logic       gnt1_s;
  logic [7:0] lock_cnt_d;

  // Grant decision: only port 1 may win while locked; in ARB a tie goes to
  // port 0 under fixed priority, otherwise to the port that did not win last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!reset) begin
      case (state_q)
        ARB: begin
          if (bus.req0 && bus.req1) begin
            if ((FIXED_PRIO != 0) || last_q) begin
              gnt0_s = 1'b1;
            end else begin
              gnt1_s = 1'b1;
            end
          end else begin
            gnt0_s = bus.req0;
            gnt1_s = bus.req1;
          end
        end
        LOCKED: begin
          gnt1_s = bus.req1;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // RAM command mux: port 1 fields only when port 1 holds the grant.
  always_comb begin
    ram_en    = gnt0_s | gnt1_s;
    ram_we    = bus.we0;
    ram_addr  = bus.addr0;
    ram_wdata = bus.wdata0;
    if (gnt1_s) begin
      ram_we    = bus.we1;
      ram_addr  = bus.addr1;
      ram_wdata = bus.wdata1;
    end else begin
      ram_we    = bus.we0;
      ram_addr  = bus.addr0;
      ram_wdata = bus.wdata0;
    end
  end

  // Next lock count if port 1 is granted while locked.
  always_comb begin
    lock_cnt_d = lock_cnt_q + 8'd1;
  end

  // Arbitration FSM, lock accounting and read-return tagging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      last_q     <= 1'b1;
      lock_cnt_q <= 8'd0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      // A read granted this cycle returns next cycle to the same port.
      rvalid0_q <= gnt0_s && !bus.we0;
      rvalid1_q <= gnt1_s && !bus.we1;

      case (state_q)
        ARB: begin
          if (gnt0_s) begin
            last_q <= 1'b0;
          end else if (gnt1_s) begin
            last_q <= 1'b1;
          end
          if (gnt1_s && bus.lock1) begin
            if (MAX_LOCK_C <= 8'd1) begin
              // The locking grant already exhausts the allowance.
              state_q    <= ARB;
              lock_cnt_q <= 8'd0;
            end else begin
              state_q    <= LOCKED;
              lock_cnt_q <= 8'd1;
            end
          end
        end
        LOCKED: begin
          // Any exit leaves last=1 so port 0 wins the next tie.
          last_q <= 1'b1;
          if (!bus.lock1) begin
            state_q    <= ARB;
            lock_cnt_q <= 8'd0;
          end else if (gnt1_s) begin
            if (lock_cnt_d == MAX_LOCK_C) begin
              state_q    <= ARB;
              lock_cnt_q <= 8'd0;
            end else begin
              lock_cnt_q <= lock_cnt_d;
            end
          end
        end
        default: begin
          state_q    <= ARB;
          lock_cnt_q <= 8'd0;
          last_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_s;
  assign bus.gnt1    = gnt1_s;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  // Both ports see the RAM data; consumers qualify it with their rvalid.
  assign bus.rdata0  = ram_rdata;
  assign bus.rdata1  = ram_rdata;

endmodule
